// File: rtl/mmio_timer_core.sv
`default_nettype none
// ============================================================================
// Module  : mmio_timer_core
// Brief   : MMIO slot-0 responder with a 64-bit prescaled timer, compare
//           match, auto-reload and level interrupt.
// Rev     : 1.0  initial release
// ============================================================================
module mmio_timer_core #(
    parameter int PRESCALE_W   = 16,
    parameter int PRESCALE_RST = 0
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        wr_done,
    output logic        rd_done,
    output logic        idle,
    output logic        slave_error,
    output logic        decode_error,
    output logic        irq
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WR_CAP  = 2'd1;
    localparam logic [1:0] c_ST_WR_DONE = 2'd2;
    localparam logic [1:0] c_ST_RD_DONE = 2'd3;

    localparam logic [7:0] c_A_CTRL     = 8'h00;
    localparam logic [7:0] c_A_STATUS   = 8'h01;
    localparam logic [7:0] c_A_COUNT_LO = 8'h02;
    localparam logic [7:0] c_A_COUNT_HI = 8'h03;
    localparam logic [7:0] c_A_CMP_LO   = 8'h04;
    localparam logic [7:0] c_A_CMP_HI   = 8'h05;
    localparam logic [7:0] c_A_PRESCALE = 8'h06;

    localparam logic [PRESCALE_W-1:0] c_PRESCALE_RST = PRESCALE_W'(PRESCALE_RST);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_accept_wr;
    logic                  w_accept_rd;
    logic                  w_commit;

    logic [7:0]            r_addr;
    logic [31:0]           r_rd_data;
    logic                  r_wr_done;
    logic                  r_rd_done;
    logic                  r_slave_error;
    logic                  r_decode_error;
    logic                  r_irq;

    logic                  r_en;
    logic                  r_autoreload;
    logic                  r_irq_en;
    logic                  r_match;
    logic [63:0]           r_count;
    logic [63:0]           r_cmp;
    logic [31:0]           r_hi_snap;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pscnt;

    logic [31:0]           w_rd_mux;
    logic                  w_rd_mapped;
    logic [31:0]           w_ps_ext;
    logic                  w_wr_mapped;
    logic                  w_wr_ro;
    logic                  w_wr_ctrl;
    logic                  w_wr_status;
    logic                  w_clr;
    logic                  w_w1c;
    logic                  w_tick;
    logic                  w_hit;

    // ------------------------------------------------------------------
    // Responder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (cs && write) begin
                    w_state_nxt = c_ST_WR_CAP;
                end else if (cs && read) begin
                    w_state_nxt = c_ST_RD_DONE;
                end
            end
            c_ST_WR_CAP:  w_state_nxt = c_ST_WR_DONE;
            c_ST_WR_DONE: if (!write) w_state_nxt = c_ST_IDLE;
            c_ST_RD_DONE: if (!read)  w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        idle        = (r_state == c_ST_IDLE);
        w_accept_wr = idle && cs && write;
        w_accept_rd = idle && cs && read && !write;
        w_commit    = (r_state == c_ST_WR_CAP);
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    generate
        if (PRESCALE_W < 32) begin : g_ps_pad
            assign w_ps_ext = {{(32-PRESCALE_W){1'b0}}, r_prescale};
        end else begin : g_ps_full
            assign w_ps_ext = r_prescale;
        end
    endgenerate

    always_comb begin
        w_rd_mux    = 32'd0;
        w_rd_mapped = 1'b1;
        case (reg_addr)
            c_A_CTRL:     w_rd_mux = {28'd0, r_irq_en, r_autoreload, 1'b0, r_en};
            c_A_STATUS:   w_rd_mux = {30'd0, r_en, r_match};
            c_A_COUNT_LO: w_rd_mux = r_count[31:0];
            c_A_COUNT_HI: w_rd_mux = r_hi_snap;
            c_A_CMP_LO:   w_rd_mux = r_cmp[31:0];
            c_A_CMP_HI:   w_rd_mux = r_cmp[63:32];
            c_A_PRESCALE: w_rd_mux = w_ps_ext;
            default:      w_rd_mapped = 1'b0;
        endcase
    end

    assign w_wr_mapped = (r_addr <= c_A_PRESCALE);
    assign w_wr_ro     = (r_addr == c_A_COUNT_LO) || (r_addr == c_A_COUNT_HI);
    assign w_wr_ctrl   = w_commit && (r_addr == c_A_CTRL);
    assign w_wr_status = w_commit && (r_addr == c_A_STATUS);
    assign w_clr       = w_wr_ctrl && wr_data[1];
    assign w_w1c       = w_wr_status && wr_data[0];

    // ------------------------------------------------------------------
    // Handshake outputs and captured access state
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_addr         <= 8'd0;
            r_rd_data      <= 32'd0;
            r_wr_done      <= 1'b0;
            r_rd_done      <= 1'b0;
            r_slave_error  <= 1'b0;
            r_decode_error <= 1'b0;
            r_hi_snap      <= 32'd0;
        end else begin
            r_wr_done <= (w_state_nxt == c_ST_WR_DONE);
            r_rd_done <= (w_state_nxt == c_ST_RD_DONE);
            if (w_accept_wr) begin
                r_addr         <= reg_addr;
                r_slave_error  <= 1'b0;
                r_decode_error <= 1'b0;
            end
            if (w_accept_rd) begin
                r_rd_data      <= w_rd_mux;
                r_slave_error  <= 1'b0;
                r_decode_error <= !w_rd_mapped;
                if (reg_addr == c_A_COUNT_LO) begin
                    r_hi_snap <= r_count[63:32];
                end
            end
            if (w_commit) begin
                r_slave_error  <= w_wr_ro;
                r_decode_error <= !w_wr_mapped;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_irq_en     <= 1'b0;
            r_cmp        <= 64'd0;
            r_prescale   <= c_PRESCALE_RST;
        end else if (w_commit) begin
            case (r_addr)
                c_A_CTRL: begin
                    r_en         <= wr_data[0];
                    r_autoreload <= wr_data[2];
                    r_irq_en     <= wr_data[3];
                end
                c_A_CMP_LO:   r_cmp[31:0]  <= wr_data;
                c_A_CMP_HI:   r_cmp[63:32] <= wr_data;
                c_A_PRESCALE: r_prescale   <= wr_data[PRESCALE_W-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timer; clr overrides the tick, and a match set beats a W1C clear
    // ------------------------------------------------------------------
    assign w_tick = r_en && (r_pscnt == r_prescale);
    assign w_hit  = w_tick && !w_clr && (r_count == r_cmp);

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_pscnt <= '0;
        end else if (w_clr || w_tick) begin
            r_pscnt <= '0;
        end else if (r_en) begin
            r_pscnt <= r_pscnt + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_count <= 64'd0;
        end else if (w_clr) begin
            r_count <= 64'd0;
        end else if (w_tick) begin
            r_count <= (w_hit && r_autoreload) ? 64'd0 : r_count + 64'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_match <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_w1c) begin
                r_match <= 1'b0;
            end
            r_irq <= r_match && r_irq_en;
        end
    end

    assign rd_data      = r_rd_data;
    assign wr_done      = r_wr_done;
    assign rd_done      = r_rd_done;
    assign slave_error  = r_slave_error;
    assign decode_error = r_decode_error;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_timer_core
// Brief   : Self-checking bench for mmio_timer_core against a tick-count model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mmio_timer_core;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h01;
    localparam logic [7:0] A_CLO    = 8'h02;
    localparam logic [7:0] A_CHI    = 8'h03;
    localparam logic [7:0] A_CMPLO  = 8'h04;
    localparam logic [7:0] A_CMPHI  = 8'h05;
    localparam logic [7:0] A_PS     = 8'h06;

    logic        aclk = 1'b0;
    logic        rst;
    logic        cs;
    logic        read;
    logic        write;
    logic [7:0]  reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr_done;
    logic        rd_done;
    logic        idle;
    logic        slave_error;
    logic        decode_error;
    logic        irq;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    int          last_commit;
    int          last_issue;
    logic [31:0] last_rdata;
    logic        last_se;
    logic        last_de;
    logic        last_irq;

    mmio_timer_core #(.PRESCALE_W(16), .PRESCALE_RST(0)) dut (
        .aclk         (aclk),
        .rst          (rst),
        .cs           (cs),
        .read         (read),
        .write        (write),
        .reg_addr     (reg_addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .wr_done      (wr_done),
        .rd_done      (rd_done),
        .idle         (idle),
        .slave_error  (slave_error),
        .decode_error (decode_error),
        .irq          (irq)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Timer enabled (pscnt=0, count=0) at edge E: after edge E+j, t = j/(p+1) ticks have occurred.
    function automatic int m_count(input int j, input int p, input int c, input bit ar);
        int t;
        t = j / (p + 1);
        return ar ? (t % (c + 1)) : t;
    endfunction

    function automatic logic m_match(input int j, input int p, input int c);
        return ((j / (p + 1)) >= (c + 1));
    endfunction

    // Tasks below are entered just after a falling edge and return just after one.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; read = 1'b0; reg_addr = a; wr_data = $urandom;
        @(negedge aclk);
        cs = 1'b0; reg_addr = 8'($urandom); wr_data = d;
        n_chk++;
        if (wr_done !== 1'b0 || idle !== 1'b0)
            $display("FAIL wr_early a=%0h: wr_done=%0b idle=%0b, expected 0/0", a, wr_done, idle);
        else n_pass++;
        @(negedge aclk);
        last_commit = cyc; last_se = slave_error; last_de = decode_error;
        n_chk++;
        if (wr_done !== 1'b1) $display("FAIL wr_done a=%0h: got %0b, expected 1", a, wr_done);
        else n_pass++;
        write = 1'b0; wr_data = $urandom;
        @(negedge aclk);
        n_chk++;
        if (wr_done !== 1'b0 || idle !== 1'b1)
            $display("FAIL wr_release a=%0h: wr_done=%0b idle=%0b, expected 0/1", a, wr_done, idle);
        else n_pass++;
    endtask

    task automatic bus_read(input logic [7:0] a);
        last_issue = cyc;
        cs = 1'b1; read = 1'b1; write = 1'b0; reg_addr = a;
        @(negedge aclk);
        cs = 1'b0; read = 1'b0; reg_addr = 8'($urandom);
        last_rdata = rd_data; last_se = slave_error; last_de = decode_error; last_irq = irq;
        n_chk++;
        if (rd_done !== 1'b1) $display("FAIL rd_latency a=%0h: rd_done=%0b, expected 1", a, rd_done);
        else n_pass++;
        @(negedge aclk);
        n_chk++;
        if (rd_done !== 1'b0 || idle !== 1'b1 || rd_data !== last_rdata)
            $display("FAIL rd_release a=%0h: rd_done=%0b idle=%0b rd_data=%h, expected 0/1/%h",
                     a, rd_done, idle, rd_data, last_rdata);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; reg_addr = 8'd0; wr_data = 32'd0;
        repeat (3) @(negedge aclk);
        n_chk++;
        if (idle !== 1'b1 || rd_data !== 32'd0 || wr_done !== 1'b0 || rd_done !== 1'b0 ||
            slave_error !== 1'b0 || decode_error !== 1'b0 || irq !== 1'b0)
            $display("FAIL reset_outputs: idle=%0b rd_data=%h wr=%0b rd=%0b se=%0b de=%0b irq=%0b, expected 1/0/0/0/0/0/0",
                     idle, rd_data, wr_done, rd_done, slave_error, decode_error, irq);
        else n_pass++;
        rst = 1'b0;
        @(negedge aclk);
        bus_read(A_PS);
        n_chk++;
        if (last_rdata !== 32'd0 || last_se !== 1'b0 || last_de !== 1'b0)
            $display("FAIL reset_prescale: rd_data=%h se=%0b de=%0b, expected 0/0/0", last_rdata, last_se, last_de);
        else n_pass++;
    endtask

    task automatic test_autoreload();
        int e;
        logic [31:0] exp;
        bus_write(A_CMPLO, 32'd5);
        bus_write(A_PS, 32'd0);
        bus_write(A_CTRL, 32'h0D);
        e = last_commit;
        repeat (14) begin
            @(negedge aclk);
            n_chk++;
            if (irq !== m_match(cyc - 1 - e, 0, 5))
                $display("FAIL ar_irq j=%0d: irq=%0b, expected %0b", cyc - e, irq, m_match(cyc - 1 - e, 0, 5));
            else n_pass++;
        end
        repeat (4) begin
            repeat ($urandom_range(0, 3)) @(negedge aclk);
            bus_read(A_CLO);
            exp = 32'(m_count(last_issue - e, 0, 5, 1'b1));
            n_chk++;
            if (last_rdata !== exp) $display("FAIL ar_count: got %h, expected %h", last_rdata, exp);
            else n_pass++;
        end
        bus_read(A_STATUS);
        n_chk++;
        if (last_rdata !== 32'h3) $display("FAIL ar_status: got %h, expected 3", last_rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        int p, c, e, j;
        bit ar, ie;
        logic [31:0] exp;
        for (int it = 0; it < 6; it++) begin
            p  = $urandom_range(0, 3);
            c  = $urandom_range(0, 6);
            ar = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            bus_write(A_CTRL, 32'h2);
            bus_write(A_STATUS, 32'h1);
            bus_write(A_PS, 32'(p));
            bus_write(A_CMPLO, 32'(c));
            bus_write(A_CMPHI, 32'd0);
            bus_write(A_CTRL, 32'h3 | (32'(ar) << 2) | (32'(ie) << 3));
            e = last_commit;
            repeat (6) begin
                repeat ($urandom_range(0, 10)) @(negedge aclk);
                if ($urandom_range(0, 1) == 1) begin
                    bus_read(A_CLO);
                    j = last_issue - e;
                    exp = 32'(m_count(j, p, c, ar));
                    n_chk++;
                    if (last_rdata !== exp)
                        $display("FAIL rnd_count p=%0d c=%0d ar=%0b j=%0d: got %h, expected %h", p, c, ar, j, last_rdata, exp);
                    else n_pass++;
                    bus_read(A_CHI);
                    n_chk++;
                    if (last_rdata !== 32'd0) $display("FAIL rnd_count_hi: got %h, expected 0", last_rdata);
                    else n_pass++;
                end else begin
                    bus_read(A_STATUS);
                    j = last_issue - e;
                    exp = {30'd0, 1'b1, m_match(j, p, c)};
                    n_chk++;
                    if (last_rdata !== exp || last_irq !== (m_match(j, p, c) & ie))
                        $display("FAIL rnd_status p=%0d c=%0d ar=%0b ie=%0b j=%0d: got %h irq=%0b, expected %h irq=%0b",
                                 p, c, ar, ie, j, last_rdata, last_irq, exp, m_match(j, p, c) & ie);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_w1c();
        int e;
        bus_write(A_CTRL, 32'h2);
        bus_write(A_STATUS, 32'h1);
        bus_write(A_PS, 32'd0);
        bus_write(A_CMPLO, 32'd1);
        bus_write(A_CTRL, 32'h0B);
        repeat (4) @(negedge aclk);
        bus_write(A_CTRL, 32'h08);
        bus_read(A_STATUS);
        n_chk++;
        if (last_rdata !== 32'h1 || last_irq !== 1'b1)
            $display("FAIL w1c_pending: status=%h irq=%0b, expected 1/1", last_rdata, last_irq);
        else n_pass++;
        bus_write(A_STATUS, 32'h1);
        n_chk++;
        if (irq !== 1'b0) $display("FAIL w1c_irq_drop: irq=%0b, expected 0", irq);
        else n_pass++;
        bus_read(A_STATUS);
        n_chk++;
        if (last_rdata !== 32'h0) $display("FAIL w1c_clear: status=%h, expected 0", last_rdata);
        else n_pass++;
        // Align the W1C commit edge with the first auto-reload match edge (every 4 ticks).
        bus_write(A_CTRL, 32'h2);
        bus_write(A_CMPLO, 32'd3);
        bus_write(A_CTRL, 32'h0F);
        e = last_commit;
        while ((cyc + 2 - e) < 4 || ((cyc + 2 - e) % 4) != 0) @(negedge aclk);
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS);
        n_chk++;
        if (last_rdata !== 32'h3) $display("FAIL w1c_set_wins: status=%h, expected 3", last_rdata);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        int e;
        logic [63:0] v;
        bus_write(A_CTRL, 32'h2);
        bus_write(A_PS, 32'd0);
        force dut.r_count = 64'h1_FFFF_FFFF;
        @(negedge aclk);
        release dut.r_count;
        bus_read(A_CLO);
        n_chk++;
        if (last_rdata !== 32'hFFFF_FFFF) $display("FAIL snap_lo: got %h, expected ffffffff", last_rdata);
        else n_pass++;
        bus_write(A_CTRL, 32'h1);
        e = last_commit;
        bus_read(A_CHI);
        n_chk++;
        if (last_rdata !== 32'h1) $display("FAIL snap_hi: got %h, expected 1", last_rdata);
        else n_pass++;
        bus_read(A_CLO);
        v = 64'h1_FFFF_FFFF + 64'(last_issue - e);
        n_chk++;
        if (last_rdata !== v[31:0]) $display("FAIL snap_lo2: got %h, expected %h", last_rdata, v[31:0]);
        else n_pass++;
        bus_read(A_CHI);
        n_chk++;
        if (last_rdata !== v[63:32]) $display("FAIL snap_hi2: got %h, expected %h", last_rdata, v[63:32]);
        else n_pass++;
        bus_write(A_CTRL, 32'h0);
        force dut.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge aclk);
        release dut.r_count;
        bus_write(A_CTRL, 32'h1);
        e = last_commit;
        bus_read(A_CLO);
        v = 64'hFFFF_FFFF_FFFF_FFFF + 64'(last_issue - e);
        n_chk++;
        if (last_rdata !== v[31:0]) $display("FAIL wrap_lo: got %h, expected %h", last_rdata, v[31:0]);
        else n_pass++;
        bus_read(A_CHI);
        n_chk++;
        if (last_rdata !== v[63:32]) $display("FAIL wrap_hi: got %h, expected %h", last_rdata, v[63:32]);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] v, pv, d;
        bus_write(A_CTRL, 32'h0);
        bus_read(A_CLO);
        v = last_rdata;
        bus_read(A_PS);
        pv = last_rdata;
        bus_write(A_CLO, $urandom);
        n_chk++;
        if (last_se !== 1'b1 || last_de !== 1'b0 || slave_error !== 1'b1)
            $display("FAIL err_ro_write: se=%0b de=%0b held_se=%0b, expected 1/0/1", last_se, last_de, slave_error);
        else n_pass++;
        bus_read(A_CLO);
        n_chk++;
        if (last_rdata !== v || last_se !== 1'b0 || last_de !== 1'b0)
            $display("FAIL err_count_kept: got %h se=%0b de=%0b, expected %h/0/0", last_rdata, last_se, last_de, v);
        else n_pass++;
        bus_write(A_CHI, $urandom);
        n_chk++;
        if (last_se !== 1'b1 || last_de !== 1'b0)
            $display("FAIL err_ro_hi: se=%0b de=%0b, expected 1/0", last_se, last_de);
        else n_pass++;
        bus_read(8'h40);
        n_chk++;
        if (last_rdata !== 32'd0 || last_se !== 1'b0 || last_de !== 1'b1 || decode_error !== 1'b1)
            $display("FAIL err_unmapped_rd: rd=%h se=%0b de=%0b held_de=%0b, expected 0/0/1/1",
                     last_rdata, last_se, last_de, decode_error);
        else n_pass++;
        bus_write(8'h07, 32'h0000_00A5);
        n_chk++;
        if (last_se !== 1'b0 || last_de !== 1'b1)
            $display("FAIL err_unmapped_wr: se=%0b de=%0b, expected 0/1", last_se, last_de);
        else n_pass++;
        bus_read(A_PS);
        n_chk++;
        if (last_rdata !== pv || last_se !== 1'b0 || last_de !== 1'b0)
            $display("FAIL err_clear: ps=%h se=%0b de=%0b, expected %h/0/0", last_rdata, last_se, last_de, pv);
        else n_pass++;
        // Read and write strobed together: write wins.
        d = $urandom;
        cs = 1'b1; read = 1'b1; write = 1'b1; reg_addr = A_CMPLO; wr_data = $urandom;
        @(negedge aclk);
        cs = 1'b0; read = 1'b0; wr_data = d;
        n_chk++;
        if (rd_done !== 1'b0 || idle !== 1'b0)
            $display("FAIL both_strobes: rd_done=%0b idle=%0b, expected 0/0", rd_done, idle);
        else n_pass++;
        @(negedge aclk);
        write = 1'b0;
        @(negedge aclk);
        bus_read(A_CMPLO);
        n_chk++;
        if (last_rdata !== d) $display("FAIL both_strobes_data: got %h, expected %h", last_rdata, d);
        else n_pass++;
    endtask

    task automatic test_reset_midaccess();
        int e;
        logic [31:0] exp;
        bus_write(A_PS, 32'd9);
        cs = 1'b1; write = 1'b1; reg_addr = A_PS; wr_data = 32'd7;
        @(negedge aclk);
        rst = 1'b1; cs = 1'b0; write = 1'b0;
        @(negedge aclk);
        rst = 1'b0;
        n_chk++;
        if (idle !== 1'b1 || wr_done !== 1'b0)
            $display("FAIL rst_mid: idle=%0b wr_done=%0b, expected 1/0", idle, wr_done);
        else n_pass++;
        @(negedge aclk);
        n_chk++;
        if (wr_done !== 1'b0) $display("FAIL rst_mid_after: wr_done=%0b, expected 0", wr_done);
        else n_pass++;
        bus_read(A_PS);
        n_chk++;
        if (last_rdata !== 32'd0) $display("FAIL rst_mid_ps: got %h, expected 0", last_rdata);
        else n_pass++;
        bus_write(A_PS, 32'd3);
        bus_write(A_CTRL, 32'h1);
        e = last_commit;
        repeat (4) begin
            repeat ($urandom_range(0, 6)) @(negedge aclk);
            bus_read(A_CLO);
            exp = 32'(m_count(last_issue - e, 3, 0, 1'b0));
            n_chk++;
            if (last_rdata !== exp) $display("FAIL ps3_count j=%0d: got %h, expected %h", last_issue - e, last_rdata, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_autoreload();
        test_random();
        test_w1c();
        test_snapshot();
        test_errors();
        test_reset_midaccess();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_timer_core.md
Name: mmio_timer_core

Overview:
- Slot-side responder for MMIO slot 0 (timer), the device end of the MMIO controller's slot interface.
- Decodes chip-select/read/write/reg_addr strobes from the controller and returns rd_data, rd_done, wr_done, idle and error flags with the handshake timing the controller expects.
- Contains a 64-bit free-running timer with prescaler, compare match, auto-reload and an interrupt output.

Parameters:
PRESCALE_W, 16, width of prescale register and prescale counter (1..32)
PRESCALE_RST, 0, reset value of PRESCALE register

Ports:
aclk  in  1  system clock
rst  in  1  reset
cs  in  1  chip select for this slot (controller slot_chip_select[0])
read  in  1  read strobe
write  in  1  write strobe
reg_addr  in  8  word register index
wr_data  in  32  write data (registered by controller; valid one cycle after cs&write)
rd_data  out  32  read data, held until next read completes
wr_done  out  1  write committed, held
rd_done  out  1  read data valid
idle  out  1  responder FSM in IDLE
slave_error  out  1  access error (write to read-only register)
decode_error  out  1  unmapped reg_addr
irq  out  1  match interrupt (level)

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. While rst is high at a rising aclk edge, the block returns to reset state.
- Reset values: rd_data=0, wr_done=0, rd_done=0, slave_error=0, decode_error=0, irq=0, idle=1.
- Reset state: FSM=IDLE, all registers 0, except PRESCALE=PRESCALE_RST.
- Register map (reg_addr, word index):
  - 0x00 CTRL RW: [0] en, [1] clr (self-clearing, reads 0), [2] autoreload, [3] irq_en.
  - 0x01 STATUS: [0] match, W1C; [1] running (=en), RO.
  - 0x02 COUNT_LO RO. Reading it latches count[63:32] into hi_snap.
  - 0x03 COUNT_HI RO. Returns hi_snap.
  - 0x04 CMP_LO RW; 0x05 CMP_HI RW.
  - 0x06 PRESCALE RW. Bits above PRESCALE_W read 0.
  - All other addresses: decode_error.
- FSM states and transitions:
  - IDLE -> WR_CAP on cs&write. Write wins if read and write are both asserted.
  - IDLE -> RD_DONE on cs&read.
  - WR_CAP (1 cycle): commit wr_data to target register at end of cycle. Set wr_done=1 and error flags. -> WR_DONE.
  - WR_DONE: wr_done held. Ignore cs. -> IDLE when write==0.
  - RD_DONE: entered with rd_done=1 and rd_data/error flags registered on the transition edge. Ignore cs. -> IDLE when read==0.
- Read latency: 1 cycle from cs&read sampled to rd_done=1.
- Write latency: cs&write sampled at edge N; wr_data is sampled during cycle N+1; wr_done=1 from cycle N+2.
- Done/error clearing:
  - wr_done clears on leaving WR_DONE.
  - rd_done clears on leaving RD_DONE.
  - slave_error/decode_error hold until the next access is accepted.
  - rd_data holds until the next read.
- Error accesses:
  - Reads of unmapped addresses return 0.
  - Writes to COUNT_LO/COUNT_HI or unmapped addresses change no state.
  - Write to read-only: slave_error=1. Unmapped: decode_error=1 (slave_error=0).
- idle = (state==IDLE).
- Timer:
  - tick when en && pscnt==PRESCALE. On tick, pscnt<=0; otherwise, if en, pscnt++.
  - On tick, count<=count+1, wrapping 2^64-1 -> 0.
  - Match: on a tick where count==CMP, set match=1. If autoreload, count<=0 instead of incrementing.
- Simultaneous events:
  - clr write clears count and pscnt the same edge, overriding tick.
  - Hardware match set and W1C clear in the same cycle: set wins.
  - CMP written in the same cycle as a tick: compare uses the old CMP.
- irq = match & irq_en, registered (1-cycle delay after match/irq_en changes).
- Reset mid-access: FSM -> IDLE, done/error flags drop the next cycle.

Test Plan:
- Reset -> idle=1, all outputs 0. Read PRESCALE with PRESCALE_RST=0 -> rd_done 1 cycle after cs&read, rd_data=0.
- Write CMP_LO=5, PRESCALE=0, CTRL=0x0D (en, autoreload, irq_en) -> wr_done at N+2 each. Count runs 0..5 then 0; match=1 and irq=1 one cycle after the match; reading STATUS returns 0x3.
- W1C STATUS=1 while match pending and no new tick -> match=0, irq=0 next cycle. Same cycle as a new match -> match stays 1.
- Preload state so count=0x1_FFFF_FFFF, en=0. Read COUNT_LO -> 0xFFFFFFFF, then COUNT_HI -> 0x1 even after re-enabling count between the two reads.
- Write reg_addr 0x02 -> wr_done=1, slave_error=1, count unchanged. Read reg_addr 0x40 -> rd_data=0, decode_error=1. Next valid access clears both flags.
- Assert rst in WR_CAP -> register not committed, wr_done stays 0, idle=1 after the reset cycle. PRESCALE=3 -> count increments every 4 cycles.
